// File: rtl/gcd_lcm_coproc.sv
// Iterative GCD/LCM coprocessor.
// GCD is computed by subtractive Euclid and LCM by stepping multiples of
// each operand until they meet. Each step takes one clock.
// The result and the overflow flag are held until the next completion.
module gcd_lcm_coproc #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow
);

    typedef enum logic {
        IDLE,
        CALC
    } state_t;

    state_t       state_q, state_d;
    logic         op_q, op_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic [W-1:0] result_q, result_d;
    logic         overflow_q, overflow_d;
    logic [W:0]   x_sum;
    logic [W:0]   y_sum;

    // Next-state logic: accept a request in IDLE, then run one Euclid or LCM step per clock.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        result_d   = result_q;
        overflow_d = overflow_q;
        // The sums are one bit wider than the operands. A set top bit means the LCM
        // search has run past the largest value that fits in W bits.
        x_sum      = {1'b0, x_q} + {1'b0, a_q};
        y_sum      = {1'b0, y_q} + {1'b0, b_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = a;
                    b_d     = b;
                    x_d     = a;
                    y_d     = b;
                    busy_d  = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if ((a_q == '0) || (b_q == '0)) begin
                    // A zero operand finishes at once: gcd(0,n)=n and lcm(0,n)=0.
                    result_d   = op_q ? '0 : (a_q | b_q);
                    overflow_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (x_q == y_q) begin
                    result_d   = x_q;
                    overflow_d = 1'b0;
                    done_d     = 1'b1;
                    busy_d     = 1'b0;
                    state_d    = IDLE;
                end else if (!op_q) begin
                    if (x_q > y_q) begin
                        x_d = x_q - y_q;
                    end else begin
                        y_d = y_q - x_q;
                    end
                end else if (x_q < y_q) begin
                    if (x_sum[W]) begin
                        result_d   = '0;
                        overflow_d = 1'b1;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        x_d = x_sum[W-1:0];
                    end
                end else begin
                    if (y_sum[W]) begin
                        result_d   = '0;
                        overflow_d = 1'b1;
                        done_d     = 1'b1;
                        busy_d     = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        y_d = y_sum[W-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset clears everything, including an operation in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            op_q       <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            x_q        <= '0;
            y_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            x_q        <= x_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// Testbench for gcd_lcm_coproc.
// It applies directed vectors, hand-written corner sequences, and randomized
// operations. All results are checked against an arithmetic reference model.
module tb_gcd_lcm_coproc;

    logic        clk;
    logic        reset;
    logic        start;
    logic        opIn;
    logic [31:0] aIn;
    logic [31:0] bIn;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        overflow;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expRes;
        logic        expOvf;
        int          expLat;
    } vecT;

    vecT vecs[10];

    gcd_lcm_coproc #(.W(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (opIn),
        .a        (aIn),
        .b        (bIn),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: Euclid by remainder
    function automatic logic [31:0] modelGcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Reference model: expected result and overflow for either operation
    task automatic modelOp(input logic op, input logic [31:0] x, input logic [31:0] y,
                           output logic [31:0] res, output logic ovf);
        logic [63:0] l;
        ovf = 1'b0;
        if (!op) begin
            res = modelGcd(x, y);
        end else if (x == 0 || y == 0) begin
            res = 0;
        end else begin
            l = 64'(x / modelGcd(x, y)) * 64'(y);
            ovf = (l > 64'h0000_0000_FFFF_FFFF);
            res = ovf ? 32'd0 : l[31:0];
        end
    endtask

    // Issue one request from idle and wait for done, starting #1 after a clock edge.
    // lat is the number of edges from the accepting edge to the edge that raised done.
    task automatic applyStimulus(input logic op, input logic [31:0] x, input logic [31:0] y,
                                 input int maxCycles, output logic [31:0] res,
                                 output logic ovf, output int lat, output bit ok);
        start = 1'b1;
        opIn  = op;
        aIn   = x;
        bIn   = y;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_accept", 64'(busy), 64'd1);
        ok  = 1'b0;
        lat = 0;
        for (int i = 1; i <= maxCycles; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok  = 1'b1;
                lat = i;
                break;
            end
        end
        res = result;
        ovf = overflow;
        checkOutput("no_timeout", 64'(ok), 64'd1);
        if (ok) checkOutput("busy_low_on_done", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [31:0] res;
        logic [31:0] expRes;
        logic        ovf;
        logic        expOvf;
        int          lat;
        bit          ok;
        int          doneHits;
        logic        rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{"gcd_75_50",   1'b0, 32'd75,        32'd50,        32'd25, 1'b0, 3};
        vecs[1] = '{"lcm_25_5",    1'b1, 32'd25,        32'd5,         32'd25, 1'b0, 5};
        vecs[2] = '{"lcm_4_6",     1'b1, 32'd4,         32'd6,         32'd12, 1'b0, 4};
        vecs[3] = '{"lcm_7_7",     1'b1, 32'd7,         32'd7,         32'd7,  1'b0, 1};
        vecs[4] = '{"gcd_0_9",     1'b0, 32'd0,         32'd9,         32'd9,  1'b0, 1};
        vecs[5] = '{"gcd_0_0",     1'b0, 32'd0,         32'd0,         32'd0,  1'b0, 1};
        vecs[6] = '{"lcm_0_9",     1'b1, 32'd0,         32'd9,         32'd0,  1'b0, 1};
        vecs[7] = '{"lcm_ovf",     1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd0,  1'b1, 1};
        vecs[8] = '{"gcd_12_8",    1'b0, 32'd12,        32'd8,         32'd4,  1'b0, 3};
        vecs[9] = '{"gcd_1_5",     1'b0, 32'd1,         32'd5,         32'd1,  1'b0, 5};

        reset = 1'b0;
        start = 1'b0;
        opIn  = 1'b0;
        aIn   = '0;
        bIn   = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_done", 64'(done), 64'd0);
        checkOutput("reset_result", 64'(result), 64'd0);
        checkOutput("reset_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, including the overflow case followed by a clearing GCD
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 100, res, ovf, lat, ok);
            checkOutput({vecs[i].name, "_result"}, 64'(res), 64'(vecs[i].expRes));
            checkOutput({vecs[i].name, "_overflow"}, 64'(ovf), 64'(vecs[i].expOvf));
            checkOutput({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].expLat));
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_done_drops"}, 64'(done), 64'd0);
            checkOutput({vecs[i].name, "_result_held"}, 64'(result), 64'(vecs[i].expRes));
        end

        // Hold start high with changing operands while busy, then chain a new op on the done cycle
        start = 1'b1;
        opIn  = 1'b0;
        aIn   = 32'd75;
        bIn   = 32'd50;
        @(posedge clk);
        #1;
        doneHits = 0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                doneHits++;
                lat = i;
                opIn = 1'b0;
                aIn  = 32'd12;
                bIn  = 32'd8;
                break;
            end
            opIn = $urandom_range(0, 1);
            aIn  = $urandom_range(1, 1000);
            bIn  = $urandom_range(1, 1000);
        end
        checkOutput("held_start_done_seen", 64'(doneHits), 64'd1);
        checkOutput("held_start_result", 64'(result), 64'd25);
        checkOutput("held_start_latency", 64'(lat), 64'd3);
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("chain_accept_busy", 64'(busy), 64'd1);
        checkOutput("chain_done_single_pulse", 64'(done), 64'd0);
        ok = 1'b0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("chain_no_timeout", 64'(ok), 64'd1);
        checkOutput("chain_result", 64'(result), 64'd4);

        // Asynchronous reset in the middle of a long GCD
        @(posedge clk);
        #1;
        start = 1'b1;
        opIn  = 1'b0;
        aIn   = 32'd1;
        bIn   = 32'd200;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("pre_reset_busy", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        checkOutput("async_reset_busy", 64'(busy), 64'd0);
        checkOutput("async_reset_done", 64'(done), 64'd0);
        checkOutput("async_reset_result", 64'(result), 64'd0);
        checkOutput("async_reset_overflow", 64'(overflow), 64'd0);
        #1;
        reset = 1'b1;
        doneHits = 0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) doneHits++;
        end
        checkOutput("no_done_after_reset", 64'(doneHits), 64'd0);
        applyStimulus(1'b0, 32'd75, 32'd50, 100, res, ovf, lat, ok);
        checkOutput("post_reset_gcd_result", 64'(res), 64'd25);
        @(posedge clk);
        #1;

        // Randomized operations: mostly small operands, some zeros, and some large LCMs that must overflow
        for (int n = 0; n < 60; n++) begin
            rop = $urandom_range(0, 1);
            ra  = $urandom_range(1, 255);
            rb  = $urandom_range(1, 255);
            if ($urandom_range(0, 9) == 0) ra = 0;
            if ($urandom_range(0, 9) == 0) rb = 0;
            if ($urandom_range(0, 7) == 0) begin
                rop = 1'b1;
                ra  = $urandom | 32'h8000_0000;
                rb  = $urandom | 32'h8000_0000;
            end
            modelOp(rop, ra, rb, expRes, expOvf);
            applyStimulus(rop, ra, rb, 2000, res, ovf, lat, ok);
            if (res !== expRes || ovf !== expOvf)
                $display("[TB] random op=%0d a=%0h b=%0h", rop, ra, rb);
            checkOutput("random_result", 64'(res), 64'(expRes));
            checkOutput("random_overflow", 64'(ovf), 64'(expOvf));
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
